// File: rtl/ahb_bridge_pkg.sv
// Shared types and helpers for the AHB-lite slave posted-write bridge.
// Contents: AHB transfer type / size enums, bridge FSM states, HRESP
// encodings and the byte-strobe helper used at address-phase accept.
package ahb_bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_ERR1     = 3'd5,
        ST_ERR2     = 3'd6
    } bridge_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // 2**size ones shifted up to the byte lane given by lsb. Callers
    // truncate to their strobe width; oversize values are rejected earlier.
    function automatic logic [7:0] size2strb(input hsize_t size, input logic [2:0] lsb);
        logic [15:0] ones;
        ones = (16'd1 << (8'd1 << size)) - 16'd1;
        return 8'(ones << lsb);
    endfunction

endpackage

// File: rtl/ahb_wr_fifo.sv
// Registered synchronous FIFO holding posted-write entries.
// Ports: i_clk_ahb/i_rst_ahb clock and async active-high reset; push/wdata
// write side; pop/rdata read side (rdata shows the head entry); full,
// empty and count status. A push while full is taken when a pop happens
// in the same cycle.
module ahb_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk_ahb,
    input  logic                     i_rst_ahb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ahb_slave_posted_bridge.sv
// AHB-lite slave to native valid/ready bridge with a posted-write FIFO.
// Ports:
//   i_clk_ahb, i_rst_ahb            clock, async active-high reset
//   i_hselx/i_hready/i_htrans/i_hwrite/i_hsize/i_haddr/i_hwdata  AHB in
//   o_hreadyout/o_hresp/o_hrdata    AHB response
//   o_valid/i_ready/o_rd0_wr1/o_addr/o_wr_data/o_wr_strb  native request
//   i_rd_valid/i_rd_err/i_rd_data   native read response
//   o_wr_err_irq/i_irq_clr          sticky posted-write error flag
// Writes complete on the AHB side as soon as they are queued; reads wait
// for the queue to drain so they never overtake earlier writes.
module ahb_slave_posted_bridge
    import ahb_bridge_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          WR_DEPTH    = 4,
    parameter int unsigned ADDR_LIMIT  = 'h1000,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic                      i_clk_ahb,
    input  logic                      i_rst_ahb,
    input  logic                      i_hselx,
    input  logic                      i_hready,
    input  logic                      i_hwrite,
    input  logic [1:0]                i_htrans,
    input  logic [2:0]                i_hsize,
    input  logic [ADDR_WIDTH-1:0]     i_haddr,
    input  logic [DATA_WIDTH-1:0]     i_hwdata,
    output logic                      o_hreadyout,
    output logic                      o_hresp,
    output logic [DATA_WIDTH-1:0]     o_hrdata,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0]     o_addr,
    output logic [DATA_WIDTH-1:0]     o_wr_data,
    output logic [DATA_WIDTH/8-1:0]   o_wr_strb,
    input  logic                      i_rd_valid,
    input  logic                      i_rd_err,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    output logic                      o_wr_err_irq,
    input  logic                      i_irq_clr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SZ_MAX = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(WR_DEPTH) + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIM = ADDR_WIDTH'(ADDR_LIMIT);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
    } wr_entry_t;

    localparam int ENTRY_W = $bits(wr_entry_t);

    bridge_state_t         state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STRB_W-1:0]     strb_q;
    logic [TMR_W-1:0]      timer;

    logic                  accept;
    logic                  take_next;
    logic                  acc_err;
    logic [STRB_W-1:0]     acc_strb;
    bridge_state_t         acc_state;
    logic                  acc_hready;
    logic                  acc_hresp;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      count_next;
    wr_entry_t             fifo_in;
    wr_entry_t             fifo_head;

    assign accept = i_hselx & i_hready &
                    ((i_htrans == HTRANS_NONSEQ) | (i_htrans == HTRANS_SEQ));

    // States in which the current data phase is finishing this cycle, so
    // the next address phase decides where the FSM goes.
    assign take_next = (state == ST_IDLE) | (state == ST_ERR2) |
                       ((state == ST_WR_DATA) & o_hreadyout);

    assign fifo_push  = (state == ST_WR_DATA) & o_hreadyout;
    assign fifo_pop   = ~fifo_empty & i_ready;
    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign fifo_in    = '{addr: addr_q, data: i_hwdata, strb: strb_q};

    ahb_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WR_DEPTH)
    ) u_wr_fifo (
        .i_clk_ahb (i_clk_ahb),
        .i_rst_ahb (i_rst_ahb),
        .push      (fifo_push),
        .wdata     (fifo_in),
        .pop       (fifo_pop),
        .rdata     (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Decode of a newly accepted address phase.
    always_comb begin
        acc_err = (i_haddr >= ADDR_LIM) ||
                  (i_hsize > 3'(SZ_MAX)) ||
                  ((i_haddr[2:0] & 3'((8'd1 << i_hsize) - 8'd1)) != 3'd0);
        acc_strb   = STRB_W'(size2strb(hsize_t'(i_hsize), 3'(i_haddr[SZ_MAX-1:0])));
        acc_state  = ST_IDLE;
        acc_hready = 1'b1;
        acc_hresp  = HRESP_OKAY;
        if (accept) begin
            if (acc_err) begin
                acc_state  = ST_ERR1;
                acc_hready = 1'b0;
                acc_hresp  = HRESP_ERROR;
            end else if (i_hwrite) begin
                // Zero-wait data phase only if a slot is free after this edge.
                acc_state  = ST_WR_DATA;
                acc_hready = (count_next < CNT_W'(WR_DEPTH));
            end else if (count_next == '0) begin
                // Nothing left to drain: issue the read straight away.
                acc_state  = ST_RD_REQ;
                acc_hready = 1'b0;
            end else begin
                acc_state  = ST_RD_DRAIN;
                acc_hready = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            state       <= ST_IDLE;
            o_hreadyout <= 1'b1;
            o_hresp     <= HRESP_OKAY;
            o_hrdata    <= '0;
            addr_q      <= '0;
            strb_q      <= '0;
            timer       <= '0;
        end else if (take_next) begin
            state       <= acc_state;
            o_hreadyout <= acc_hready;
            o_hresp     <= acc_hresp;
            if (accept) begin
                addr_q <= i_haddr;
                strb_q <= acc_strb;
            end
        end else begin
            case (state)
                ST_WR_DATA: begin
                    // Stalled on a full FIFO: release once a pop frees a slot.
                    if (!fifo_full || fifo_pop)
                        o_hreadyout <= 1'b1;
                end
                ST_RD_DRAIN: begin
                    if (count_next == '0)
                        state <= ST_RD_REQ;
                end
                ST_RD_REQ: begin
                    if (i_ready) begin
                        state <= ST_RD_WAIT;
                        timer <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    if (i_rd_valid) begin
                        if (i_rd_err) begin
                            state       <= ST_ERR1;
                            o_hresp     <= HRESP_ERROR;
                        end else begin
                            state       <= ST_IDLE;
                            o_hreadyout <= 1'b1;
                            o_hrdata    <= i_rd_data;
                        end
                    end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        state   <= ST_ERR1;
                        o_hresp <= HRESP_ERROR;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Native port: the FIFO head owns it except while a read is requested;
    // reads are only requested once the FIFO is empty.
    always_comb begin
        o_valid   = ~fifo_empty;
        o_rd0_wr1 = ~fifo_empty;
        o_addr    = fifo_head.addr;
        o_wr_data = fifo_head.data;
        o_wr_strb = fifo_head.strb;
        if (state == ST_RD_REQ) begin
            o_valid   = 1'b1;
            o_rd0_wr1 = 1'b0;
            o_addr    = addr_q;
            o_wr_data = '0;
            o_wr_strb = '0;
        end
    end

    // Sticky write-reject flag; a new error beats a same-cycle clear.
    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb)
            o_wr_err_irq <= 1'b0;
        else if (fifo_pop && i_rd_err)
            o_wr_err_irq <= 1'b1;
        else if (i_irq_clr)
            o_wr_err_irq <= 1'b0;
    end

endmodule
